// File: rtl/adder_arb_pkg.sv
// ---------------------------------------------------------------------------
// adder_arb_pkg
// Shared types and constants for the adder_share_arb block.
//   NREQ_MAX    : largest supported requester count
//   add_req_t   : one adder operation (operands and add/sub select)
//   arb_state_e : response-register occupancy state
// ---------------------------------------------------------------------------
package adder_arb_pkg;

    localparam int NREQ_MAX = 8;

    typedef struct packed {
        logic [31:0] in0;
        logic [31:0] in1;
        logic        sub;
    } add_req_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/adder_bit32.sv
// ---------------------------------------------------------------------------
// adder_bit32
// 32-bit two's-complement adder/subtractor with signed-overflow flag.
// Ports:
//   a, b : operands
//   sub  : 1 = a - b, 0 = a + b
//   sum  : result, wraps mod 2^32
//   ovf  : signed overflow of the operation
// ---------------------------------------------------------------------------
module adder_bit32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        ovf
);

    logic [31:0] b_eff;

    // Subtraction as a + ~b + 1; the +1 enters as the carry-in.
    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + {31'd0, sub};

    // Overflow when both adder inputs share a sign the result does not.
    assign ovf   = (a[31] == b_eff[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches from ptr upward, wrapping
// NREQ-1 -> 0, and picks the first asserted request.
// Ports:
//   req      : request vector
//   ptr      : highest-priority index for this search
//   en       : allows the one-hot grant to assert
//   grant    : one-hot grant (zero when en=0 or no request)
//   idx      : encoded index of the winner (valid when any=1)
//   any      : at least one request is asserted
//   next_ptr : (idx + 1) mod NREQ, the pointer to load after a grant
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any,
    output logic [IDW-1:0]  next_ptr
);

    always_comb begin
        logic [IDW-1:0] j;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise synthesis infers a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IDW'((int'(ptr) + k) % NREQ);
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
        if (en && any) begin
            grant[idx] = 1'b1;
        end
    end

    assign next_ptr = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;

endmodule

// File: rtl/adder_share_arb.sv
// ---------------------------------------------------------------------------
// adder_share_arb
// Shares one adder_bit32 among NREQ requesters. A round-robin arbiter picks
// one valid request per cycle; its operands are muxed into the adder and the
// result is captured into a single registered response port tagged with the
// requester index. A held response can drain and be replaced in the same
// cycle, giving one operation per cycle under continuous demand.
//
// Optional build macro: ADD_ARB_STATS_EN adds grant_cnt, one saturating
// 16-bit grant counter per requester.
//
// Ports:
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   req_valid  : per-requester operation valid
//   req_ready  : per-requester accept, one-hot or zero
//   req_in0/1  : per-requester operands A and B
//   req_sub    : per-requester 1 = in0 - in1, 0 = in0 + in1
//   rsp_valid  : response register holds a result
//   rsp_ready  : consumer accepts the response
//   rsp_id     : requester index of the held result
//   rsp_out    : 32-bit sum/difference
//   rsp_ovf    : signed overflow of the held result
//   grant_cnt  : (ADD_ARB_STATS_EN only) per-requester grant counters
// ---------------------------------------------------------------------------
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_in0,
    input  logic [NREQ-1:0][31:0] req_in1,
    input  logic [NREQ-1:0]       req_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [31:0]           rsp_out,
    output logic                  rsp_ovf
`ifdef ADD_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][15:0] grant_cnt
`endif
);

    arb_state_e     state;
    logic [IDW-1:0] rr_ptr;

    logic            can_accept;
    logic            fire;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic [IDW-1:0]  next_ptr;

    add_req_t        sel;
    logic [31:0]     sum;
    logic            ovf;

    // The register can take a new result when empty, or when the held one
    // leaves this same cycle.
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign fire       = win_any && can_accept;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .en       (can_accept && rst_n),
        .grant    (grant),
        .idx      (win_idx),
        .any      (win_any),
        .next_ptr (next_ptr)
    );

    assign req_ready = grant;

    assign sel = '{in0: req_in0[win_idx], in1: req_in1[win_idx], sub: req_sub[win_idx]};

    adder_bit32 u_add (
        .a   (sel.in0),
        .b   (sel.in1),
        .sub (sel.sub),
        .sum (sum),
        .ovf (ovf)
    );

    assign rsp_valid = (state == FULL);

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            rr_ptr  <= '0;
            rsp_id  <= '0;
            rsp_out <= '0;
            rsp_ovf <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (fire) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    // Without rsp_ready nothing moves: the result is held.
                    if (rsp_ready && !win_any) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase

            if (fire) begin
                rsp_id  <= win_idx;
                rsp_out <= sum;
                rsp_ovf <= ovf;
                rr_ptr  <= next_ptr;
            end
        end
    end

`ifdef ADD_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int g = 0; g < NREQ; g++) begin
                if (grant[g] && (grant_cnt[g] != 16'hFFFF)) begin
                    grant_cnt[g] <= grant_cnt[g] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
